// File: rtl/life_gen_ctrl.sv
// life_gen_ctrl: generation scheduler for the Life cell array.
// Turns step/run/clear keys and a speed setting into whole-pass enables.
module life_gen_ctrl #(
    parameter int LOG2X = 3,
    parameter int LOG2Y = 3,
    parameter int SPW   = 4,
    parameter int GENW  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   key_step,
    input  logic                   key_run,
    input  logic                   key_clr,
    input  logic [SPW-1:0]         speed,
    output logic [LOG2X+LOG2Y-1:0] cnt,
    output logic                   upd_en,
    output logic                   clr_en,
    output logic                   running,
    output logic [GENW-1:0]        gen_cnt
);

    localparam int N = LOG2X + LOG2Y;

    typedef enum logic [1:0] {
        IDLE,
        UPD,
        CLR
    } state_t;

    // key order in the vectors: [0] step, [1] run, [2] clear
    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [2:0]      r_sync_d;
    logic [2:0]      w_keys;
    logic [2:0]      w_ev;

    logic [N-1:0]    r_cnt;
    logic            w_last;

    state_t          r_state;
    state_t          w_next;
    logic            r_upd_en;
    logic            r_clr_en;
    logic [GENW-1:0] r_gen;

    logic            r_running;
    logic            r_step_pend;
    logic            r_clr_pend;
    logic [SPW-1:0]  r_pace;
    logic            w_pace_hit;

    assign w_keys     = {key_clr, key_run, key_step};
    assign w_ev       = r_sync_d & ~r_sync2;
    assign w_last     = (r_cnt == {N{1'b1}});
    assign w_pace_hit = r_running && (r_pace == speed);

    assign cnt     = r_cnt;
    assign upd_en  = r_upd_en;
    assign clr_en  = r_clr_en;
    assign running = r_running;
    assign gen_cnt = r_gen;

    // two-flop synchronizers plus a delay flop for release detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_sync_d <= '0;
        end else begin
            r_sync1  <= w_keys;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    // free-running cell scan address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // next pass type, highest priority first
    always_comb begin
        w_next = IDLE;
        priority case (1'b1)
            r_clr_pend:  w_next = CLR;
            r_step_pend: w_next = UPD;
            w_pace_hit:  w_next = UPD;
            default:     w_next = IDLE;
        endcase
    end

    // pass state, enables and generation count move only at the wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_upd_en <= 1'b0;
            r_clr_en <= 1'b0;
            r_gen    <= '0;
        end else if (w_last) begin
            r_state  <= w_next;
            r_upd_en <= (w_next == UPD);
            r_clr_en <= (w_next == CLR);
            if (r_state == UPD) begin
                r_gen <= r_gen + 1'b1;
            end else if (r_state == CLR) begin
                r_gen <= '0;
            end
        end
    end

    // pending flags: a set flag is always consumed at the next wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_step_pend <= 1'b0;
            r_clr_pend  <= 1'b0;
        end else begin
            r_step_pend <= (r_step_pend & ~w_last) | w_ev[0];
            r_clr_pend  <= (r_clr_pend & ~w_last) | w_ev[2];
        end
    end

    // run/pause toggle; a clear launch always stops free-run
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_running <= 1'b0;
        end else if (w_last && (w_next == CLR)) begin
            r_running <= 1'b0;
        end else if (w_ev[1]) begin
            r_running <= ~r_running;
        end
    end

    // idle-pass pacing between generations while running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pace <= '0;
        end else if (!r_running) begin
            r_pace <= '0;
        end else if (w_last) begin
            if (w_pace_hit || (w_next == UPD)) begin
                r_pace <= '0;
            end else begin
                r_pace <= r_pace + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_life_gen_ctrl.sv
// tb_life_gen_ctrl: directed and random key stimulus for life_gen_ctrl
// against a pass-level behavioural model.
module tb_life_gen_ctrl;

    logic       clk;
    logic       reset;
    logic [2:0] kv;
    logic [3:0] speed;
    logic [5:0] cnt;
    logic       upd_en;
    logic       clr_en;
    logic       running;
    logic [15:0] gen_cnt;

    int n_chk = 0;
    int n_err = 0;
    int n_edge = 0;

    int q_s[$];
    int q_r[$];
    int q_c[$];

    // model: state 0 idle, 1 update, 2 clear
    int m_cnt, m_state, m_run, m_step, m_clr, m_pace, m_gen;

    life_gen_ctrl #(
        .LOG2X(3), .LOG2Y(3), .SPW(4), .GENW(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_step(kv[0]),
        .key_run(kv[1]),
        .key_clr(kv[2]),
        .speed(speed),
        .cnt(cnt),
        .upd_en(upd_en),
        .clr_en(clr_en),
        .running(running),
        .gen_cnt(gen_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, act, exp, $time);
        end
    endtask

    // a release is seen by the controller three rising edges later
    task automatic rel_key(input int k);
        kv[k] = 1'b0;
        if (k == 0) q_s.push_back(n_edge + 3);
        if (k == 1) q_r.push_back(n_edge + 3);
        if (k == 2) q_c.push_back(n_edge + 3);
    endtask

    task automatic model_edge();
        bit evs, evr, evc, last, consumed_s, consumed_c;
        int ns, np, nr;
        evs = (q_s.size() > 0) && (q_s[0] == n_edge);
        evr = (q_r.size() > 0) && (q_r[0] == n_edge);
        evc = (q_c.size() > 0) && (q_c[0] == n_edge);
        if (evs) void'(q_s.pop_front());
        if (evr) void'(q_r.pop_front());
        if (evc) void'(q_c.pop_front());
        last = (m_cnt == 63);
        ns = m_state;
        if (last) begin
            if (m_state == 1) m_gen = (m_gen + 1) % 65536;
            else if (m_state == 2) m_gen = 0;
            if (m_clr != 0) ns = 2;
            else if (m_step != 0) ns = 1;
            else if (m_run != 0 && m_pace == int'(speed)) ns = 1;
            else ns = 0;
        end
        if (m_run == 0) np = 0;
        else if (!last) np = m_pace;
        else if (ns == 1 || m_pace == int'(speed)) np = 0;
        else np = (m_pace + 1) % 16;
        nr = (last && ns == 2) ? 0 : (m_run ^ int'(evr));
        consumed_s = last && (ns == 2 || (ns == 1 && m_step != 0));
        consumed_c = last && (ns == 2);
        m_step  = ((m_step != 0 && !consumed_s) || evs) ? 1 : 0;
        m_clr   = ((m_clr != 0 && !consumed_c) || evc) ? 1 : 0;
        m_state = ns;
        m_pace  = np;
        m_run   = nr;
        m_cnt   = (m_cnt + 1) % 64;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt = 0; m_state = 0; m_run = 0; m_step = 0;
            m_clr = 0; m_pace = 0; m_gen = 0;
            q_s.delete(); q_r.delete(); q_c.delete();
        end else begin
            n_edge++;
            model_edge();
        end
    end

    always @(negedge clk) begin
        chk("cnt", 32'(cnt), 32'(m_cnt));
        chk("upd_en", 32'(upd_en), 32'(m_state == 1));
        chk("clr_en", 32'(clr_en), 32'(m_state == 2));
        chk("running", 32'(running), 32'(m_run));
        chk("gen_cnt", 32'(gen_cnt), 32'(m_gen));
    end

    task automatic wait_cnt(input int v);
        int t = 0;
        while (m_cnt != v && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("wait_cnt_timeout", 32'(m_cnt), 32'(v));
    endtask

    task automatic press(input logic [2:0] mask, input int hold);
        for (int k = 0; k < 3; k++) if (mask[k]) kv[k] = 1'b1;
        repeat (hold) @(negedge clk);
        for (int k = 0; k < 3; k++) if (mask[k]) rel_key(k);
        repeat (3) @(negedge clk);
    endtask

    task automatic count_upd(input int passes, output int nupd);
        nupd = 0;
        repeat (passes) begin
            wait_cnt(0);
            if (upd_en) nupd++;
            @(negedge clk);
        end
    endtask

    task automatic rand_phase(input int cycles);
        int hold[3];
        int gap[3];
        int thr[3];
        thr[0] = 120; thr[1] = 400; thr[2] = 900;
        for (int k = 0; k < 3; k++) begin
            hold[k] = 0;
            gap[k] = 0;
        end
        repeat (cycles) begin
            @(negedge clk);
            if ($urandom_range(0, 499) == 0) speed = 4'($urandom_range(0, 3));
            for (int k = 0; k < 3; k++) begin
                if (hold[k] > 0) begin
                    hold[k]--;
                    if (hold[k] == 0) begin
                        rel_key(k);
                        gap[k] = 3;
                    end
                end else if (gap[k] > 0) begin
                    gap[k]--;
                end else if ($urandom_range(0, thr[k]) == 0) begin
                    kv[k] = 1'b1;
                    hold[k] = $urandom_range(2, 4);
                end
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) if (hold[k] > 0) rel_key(k);
    endtask

    initial begin
        int nu;
        kv = '0;
        speed = 4'd0;
        reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_upd", 32'(upd_en), 32'd0);
        chk("rst_clr", 32'(clr_en), 32'd0);
        chk("rst_run", 32'(running), 32'd0);
        chk("rst_gen", 32'(gen_cnt), 32'd0);
        #2 reset = 1'b1;
        repeat (70) @(negedge clk);

        // single step, second press before the boundary coalesces
        wait_cnt(20);
        press(3'b001, 2);
        wait_cnt(35);
        press(3'b001, 2);
        wait_cnt(0);
        chk("step_upd", 32'(upd_en), 32'd1);
        chk("step_gen0", 32'(gen_cnt), 32'd0);
        @(negedge clk);
        wait_cnt(63);
        chk("step_last", 32'(upd_en), 32'd1);
        @(negedge clk);
        chk("step_end", 32'(upd_en), 32'd0);
        chk("step_gen1", 32'(gen_cnt), 32'd1);

        // free run at speed 2: one update every third pass
        speed = 4'd2;
        wait_cnt(10);
        press(3'b010, 2);
        chk("run_on", 32'(running), 32'd1);
        count_upd(9, nu);
        chk("run_upd3", 32'(nu), 32'd3);
        wait_cnt(10);
        press(3'b010, 2);
        chk("run_off", 32'(running), 32'd0);
        count_upd(4, nu);
        chk("pause_upd0", 32'(nu), 32'd0);

        // clear and step in the same pass while running
        speed = 4'd0;
        wait_cnt(10);
        press(3'b010, 2);
        begin
            int t = 0;
            while (m_gen < 5 && t < 2000) begin
                @(negedge clk);
                t++;
            end
        end
        chk("gen_reach5", 32'(gen_cnt), 32'd5);
        wait_cnt(10);
        press(3'b101, 2);
        wait_cnt(0);
        chk("clr_en", 32'(clr_en), 32'd1);
        chk("clr_no_upd", 32'(upd_en), 32'd0);
        chk("clr_run0", 32'(running), 32'd0);
        @(negedge clk);
        wait_cnt(0);
        chk("clr_gen0", 32'(gen_cnt), 32'd0);
        chk("clr_done", 32'(clr_en), 32'd0);
        chk("clr_no_step", 32'(upd_en), 32'd0);

        // release whose event lands on the last cycle of the pass
        @(negedge clk);
        wait_cnt(59);
        press(3'b001, 2);
        wait_cnt(0);
        chk("late_no_upd", 32'(upd_en), 32'd0);
        @(negedge clk);
        wait_cnt(0);
        chk("late_upd", 32'(upd_en), 32'd1);

        // reset mid update pass with a step pending
        wait_cnt(10);
        press(3'b010, 2);
        count_upd(2, nu);
        wait_cnt(0);
        chk("pre_rst_upd", 32'(upd_en), 32'd1);
        wait_cnt(20);
        press(3'b001, 2);
        wait_cnt(30);
        #2 reset = 1'b0;
        #1;
        chk("rst2_cnt", 32'(cnt), 32'd0);
        chk("rst2_upd", 32'(upd_en), 32'd0);
        chk("rst2_run", 32'(running), 32'd0);
        chk("rst2_gen", 32'(gen_cnt), 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        count_upd(3, nu);
        chk("rst2_no_pend", 32'(nu), 32'd0);

        // random key traffic
        rand_phase(4000);
        repeat (70) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/life_gen_ctrl.md
Name: life_gen_ctrl

Overview:
Generation scheduler for the Life cell array. Owns the free-running cell scan counter. Turns three push-keys (single step, run/pause, clear) and a speed setting into whole-pass enables:
- upd_en: the pass computes the next generation.
- clr_en: the pass clears the array.
Enables only ever change at a pass boundary, so the cell datapath never sees a partial-frame update.

Parameters:
LOG2X, 3, log2 of grid width; X = 2^LOG2X
LOG2Y, 3, log2 of grid height; Y = 2^LOG2Y
SPW, 4, width of speed input and pace counter
GENW, 16, width of generation counter

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-low
key_step  in  1  single-step key, active-high, asynchronous to clk
key_run  in  1  run/pause toggle key, active-high, asynchronous
key_clr  in  1  clear key, active-high, asynchronous
speed  in  SPW  idle passes inserted between generations while running
cnt  out  LOG2X+LOG2Y  cell scan address
upd_en  out  1  current pass is an update pass
clr_en  out  1  current pass is a clear pass
running  out  1  free-run mode active
gen_cnt  out  GENW  generations computed since last clear

Behaviour:
- N = LOG2X+LOG2Y. A pass is 2^N cycles, from cnt==0 to cnt==2^N-1 (last).
- Reset (async, active-low): all outputs 0, state IDLE, pending flags 0, pace counter 0, key synchronizers 0. Reset asserted mid-pass aborts the pass. After release, cnt restarts at 0 in state IDLE.
- cnt increments by 1 every cycle and wraps from 2^N-1 to 0.
- Key inputs:
  - Each key passes through a 2-flop synchronizer plus a delay flop.
  - An event is the release edge: delayed sync value 1, current sync value 0. Exactly one event per press/release.
  - Worst-case latency from key release to event: 3 clk.
- Event handling:
  - run event: toggles running on the next clk.
  - step event: sets step_pend.
  - clr event: sets clr_pend.
  - Repeated events before consumption coalesce; pending flags are not counters.
  - A flag set in cycle t is first visible to the boundary decision in cycle t+1. An event arriving in the last cycle is therefore served at the following boundary.
- States: IDLE, UPD, CLR. upd_en = (state==UPD); clr_en = (state==CLR). State changes only on the clk edge where cnt wraps from last to 0.
- Pace counter (SPW bits):
  - Held at 0 while running==0.
  - While running, evaluated at each last cycle: pace_hit = (pace==speed).
  - On pace_hit, or on any UPD launch, pace returns to 0; otherwise it increments.
  - speed=0 gives back-to-back update passes.
  - speed is sampled only at the last cycle.
- Boundary decision at cnt==last, priority order:
  1. clr_pend → next state CLR; clear clr_pend and step_pend; force running=0.
  2. Else step_pend → UPD; clear step_pend.
  3. Else running && pace_hit → UPD.
  4. Else IDLE.
- Step while running is honoured immediately and restarts pacing.
- Simultaneous run event and CLR launch in the same cycle: CLR wins, running=0.
- gen_cnt:
  - Increments at the last cycle of a UPD pass (new value visible with cnt==0) and wraps at 2^GENW.
  - Set to 0 at the last cycle of a CLR pass.
- All outputs are registered; no combinational path from any key input to any output.

Test Plan:
- LOG2X=LOG2Y=3 (pass = 64 cycles). Reset low, then high → cnt counts 0..63 and back to 0; upd_en=clr_en=running=0; gen_cnt=0.
- Press and release key_step once mid-pass → upd_en=1 for exactly cnt 0..63 of the next pass, then 0; gen_cnt=1 when cnt returns to 0. A second press before the boundary still yields a single pass.
- speed=2, press/release key_run → running=1; upd_en asserted on every 3rd pass (1 update, 2 idle); gen_cnt +1 per update pass. Second key_run release → running=0, no further updates.
- Running with gen_cnt=5, release key_clr and key_step in the same pass → next pass clr_en=1, upd_en=0, running=0; gen_cnt=0 after that pass; no step pass follows.
- Key release landing exactly on the cnt==63 cycle (sync event timing) → no launch at that boundary; UPD occurs on the following boundary.
- Assert reset at cnt=30 during a UPD pass with running=1 → all outputs 0 immediately; after release, state IDLE and no pending action is executed.
